// File: rtl/ysyx_22041412_div_pkg.sv
// Shared constants and types for the RV64M divider sequencing controller.
package ysyx_22041412_div_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // op[0] = unsigned, op[1] = remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct packed {
        logic [1:0]      op;
        logic            word;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
    } div_req_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041412_div_fixup.sv
// Combinational result fixup: RISC-V divide-by-zero / signed-overflow values
// and sign-extension of W results.
module ysyx_22041412_div_fixup
    import ysyx_22041412_div_pkg::*;
(
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [XLEN-1:0] div_result_i,
    output logic            special_o,
    output logic [XLEN-1:0] result_o
);

    logic            is_signed;
    logic            is_rem;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] dividend;

    always_comb begin
        is_signed = ~op_i[0];
        is_rem    = op_i[1];
        if (word_i) begin
            div_zero = (src2_i[31:0] == 32'd0);
            overflow = is_signed && (src1_i[31:0] == 32'h8000_0000)
                                 && (src2_i[31:0] == 32'hFFFF_FFFF);
            dividend = sext32(src1_i[31:0]);
        end else begin
            div_zero = (src2_i == '0);
            overflow = is_signed && (src1_i == {1'b1, {(XLEN-1){1'b0}}})
                                 && (src2_i == '1);
            dividend = src1_i;
        end

        special_o = div_zero | overflow;
        if (div_zero) begin
            result_o = is_rem ? dividend : '1;
        end else if (overflow) begin
            result_o = is_rem ? '0 : dividend;
        end else begin
            result_o = word_i ? sext32(div_result_i[31:0]) : div_result_i;
        end
    end

endmodule

// File: rtl/ysyx_22041412_div_ctrl.sv
// EXU <-> multi-cycle divider sequencer with flush draining.
// Define DIV_CTRL_FASTPATH_EN to answer div-by-zero/overflow ops without the divider.
module ysyx_22041412_div_ctrl
    import ysyx_22041412_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            div_valid,
    output logic            div_divw,
    output logic            div_signed,
    output logic            div_mode,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_result
);

`ifdef DIV_CTRL_FASTPATH_EN
    localparam logic FASTPATH = 1'b1;
`else
    localparam logic FASTPATH = 1'b0;
`endif

    logic [2:0]      state_q, state_d;
    div_req_t        req_q, req_d;
    div_req_t        live_req;
    div_req_t        fix_req;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            fix_special;
    logic [XLEN-1:0] fix_result;
    logic            fire;
    logic            take_fast;

    assign live_req = '{op: req_op, word: req_word, src1: req_src1, src2: req_src2};

    // While idle the fast path inspects the incoming request; otherwise the held one.
    assign fix_req = (FASTPATH && state_q == ST_IDLE) ? live_req : req_q;

    ysyx_22041412_div_fixup u_fixup (
        .op_i         (fix_req.op),
        .word_i       (fix_req.word),
        .src1_i       (fix_req.src1),
        .src2_i       (fix_req.src2),
        .div_result_i (div_result),
        .special_o    (fix_special),
        .result_o     (fix_result)
    );

    assign req_ready = rst && (state_q == ST_IDLE) && !flush;
    assign fire      = req_valid && req_ready;
    assign take_fast = FASTPATH && fix_special;

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d     = state_q;
        req_d       = req_q;
        resp_data_d = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    req_d = live_req;
                    if (take_fast) begin
                        state_d     = ST_RESP;
                        resp_data_d = fix_result;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (div_out_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_RESP;
                        resp_data_d = fix_result;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            // A flush wins over a same-cycle resp_ready: the result is dropped.
            ST_RESP:  if (flush || resp_ready) state_d = ST_IDLE;
            ST_DRAIN: if (div_out_valid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_data    = resp_data_q;
    assign div_valid    = (state_q == ST_ISSUE);
    // Control flags are only driven while an op is owned, so they read 0 when idle.
    assign div_signed   = busy && !req_q.op[0];
    assign div_mode     = busy && req_q.op[1];
    assign div_divw     = busy && req_q.word;
    assign div_dividend = req_q.src1;
    assign div_divisor  = req_q.src2;

endmodule

// File: tb/tb_ysyx_22041412_div_ctrl.sv
// Self-checking bench: behavioural divider with variable latency plus a RISC-V reference model.
module tb_ysyx_22041412_div_ctrl;
    import ysyx_22041412_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_word = 1'b0;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        busy;
    logic        div_valid, div_divw, div_signed, div_mode;
    logic [63:0] div_dividend, div_divisor;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_result = '0;

    int total = 0;
    int bad   = 0;
    int div_lat = 2;
    int div_cnt = 0;
    logic [63:0] div_pending = '0;

    always #5 clk = ~clk;

    ysyx_22041412_div_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy),
        .div_valid(div_valid), .div_divw(div_divw), .div_signed(div_signed), .div_mode(div_mode),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_out_valid(div_out_valid), .div_result(div_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [1:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
        logic sgn = ~op[0];
        if (word)
            return (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic   sgn = ~op[0];
        logic   rem = op[1];
        longint x, y, r;
        logic [63:0] res;
        if (word) begin
            x = sgn ? longint'($signed(a[31:0])) : longint'({32'b0, a[31:0]});
            y = sgn ? longint'($signed(b[31:0])) : longint'({32'b0, b[31:0]});
            if (y == 0) r = rem ? x : -1;
            else        r = rem ? x % y : x / y;
            res = {{32{r[31]}}, r[31:0]};
        end else if (b == 0) begin
            res = rem ? a : '1;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            res = rem ? 64'd0 : a;
        end else if (sgn) begin
            res = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end else begin
            res = rem ? a % b : a / b;
        end
        return res;
    endfunction

    // Cycles from the fire edge to the first cycle with resp_valid.
    function automatic int exp_lat(input logic [1:0] op, input logic word,
                                   input logic [63:0] a, input logic [63:0] b, input int lat);
`ifdef DIV_CTRL_FASTPATH_EN
        if (is_special(op, word, a, b)) return 1;
`endif
        return 2 + lat;
    endfunction

    // Behavioural divider: answers div_valid after div_lat cycles with a one-cycle strobe.
    always @(posedge clk) begin
        logic [1:0] mop;
        #1;
        div_out_valid = 1'b0;
        if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
                div_out_valid = 1'b1;
                div_result    = div_pending;
            end
        end
        if (div_valid) begin
            check("div_idle_at_issue", div_cnt, 0);
            mop = {div_mode, ~div_signed};
            if (is_special(mop, div_divw, div_dividend, div_divisor)) begin
                div_pending = {$urandom, $urandom};
            end else begin
                div_pending = ref_res(mop, div_divw, div_dividend, div_divisor);
                if (div_divw) div_pending[63:32] = $urandom;
            end
            div_cnt = div_lat;
        end
    end

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic fire_req(input logic [1:0] op, input logic word, input logic [63:0] a,
                            input logic [63:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_word  = word;
        req_src1  = a;
        req_src2  = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int lat, input int hold);
        int n = 1;
        wait_ready(tag);
        fire_req(op, word, a, b);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, resp_data, exp);
            check({tag, "_hold_valid"}, resp_valid, 1);
            check({tag, "_hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_done"}, {resp_valid, busy}, 0);
    endtask

    // Flush at the given cycle after fire (1 = ISSUE, 2 = WAIT) and expect a clean drain.
    task automatic flush_run(input string tag, input int at_cycle);
        int n = 0;
        div_lat = 5;
        wait_ready(tag);
        fire_req(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        for (int c = 1; c < at_cycle; c++) @(negedge clk);
        if (at_cycle == 1) check({tag, "_div_valid"}, div_valid, 1);
        flush = 1'b1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_no_accept"}, req_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        while (!div_out_valid && n < 50) begin
            check({tag, "_drain_busy"}, busy, 1);
            check({tag, "_drain_noresp"}, resp_valid, 0);
            @(negedge clk);
            n++;
        end
        check({tag, "_strobe"}, div_out_valid, 1);
        @(negedge clk);
        check({tag, "_idle"}, {busy, resp_valid, req_ready}, 3'b001);
        div_lat = 2;
    endtask

    function automatic logic [63:0] pick_a();
        case ($urandom_range(0, 4))
            0:       return {$urandom, $urandom};
            1:       return 64'h8000_0000_0000_0000;
            2:       return {$urandom, 32'h8000_0000};
            3:       return 64'($urandom_range(0, 1000));
            default: return -64'($urandom_range(1, 1000));
        endcase
    endfunction

    function automatic logic [63:0] pick_b();
        case ($urandom_range(0, 5))
            0:       return {$urandom, $urandom};
            1:       return 64'd0;
            2:       return '1;
            3:       return {$urandom, 32'h0};
            4:       return 64'($urandom_range(1, 20));
            default: return {$urandom, 32'hFFFF_FFFF};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  op;
        logic        word;
        logic [63:0] a, b;
        int          n;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_div_valid", div_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_div_flags", {div_signed, div_mode, div_divw}, 0);
        check("rst_div_dividend", div_dividend, 0);
        check("rst_div_divisor", div_divisor, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        do_op("div_m7_2",   OP_DIV,  1'b0, -64'sd7, 64'd2, -64'sd3, 4, 0);
        do_op("rem_m7_2",   OP_REM,  1'b0, -64'sd7, 64'd2, -64'sd1, 4, 0);
        do_op("divuw_sext", OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1,
              64'hFFFF_FFFF_8000_0000, 4, 0);
        do_op("divu_zero",  OP_DIVU, 1'b0, 64'd12345, 64'd0, '1,
              exp_lat(OP_DIVU, 1'b0, 64'd12345, 64'd0, 2), 0);
        do_op("remw_zero",  OP_REM,  1'b1, 64'h1_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001,
              exp_lat(OP_REM, 1'b1, 64'h1_8000_0001, 64'd0, 2), 0);
        do_op("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1,
              64'h8000_0000_0000_0000, exp_lat(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 2), 0);
        do_op("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0,
              exp_lat(OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 2), 0);
        do_op("divw_ovf",   OP_DIV,  1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000,
              exp_lat(OP_DIV, 1'b1, 64'h8000_0000, '1, 2), 0);

        flush_run("flush_wait", 2);
        do_op("divu_after_flush", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 4, 0);
        flush_run("flush_issue", 1);
        do_op("hold5", OP_DIV, 1'b0, 64'd1000, -64'sd3, -64'sd333, 4, 5);

        // Flush together with resp_ready in RESP: result dropped, back to idle.
        wait_ready("flush_resp");
        fire_req(OP_REMU, 1'b0, 64'd50, 64'd8);
        n = 1;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("flush_resp_valid", resp_valid, 1);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b0;
        check("flush_resp_idle", {resp_valid, busy}, 0);

        for (int i = 0; i < 60; i++) begin
            op      = 2'($urandom_range(0, 3));
            word    = 1'($urandom_range(0, 1));
            a       = pick_a();
            b       = pick_b();
            div_lat = $urandom_range(1, 4);
            do_op("rnd", op, word, a, b, ref_res(op, word, a, b),
                  exp_lat(op, word, a, b, div_lat), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_div_ctrl.md
# ysyx_22041412_div_ctrl

Sequencing controller between the EXU and the multi-cycle divider `ysyx_22041412_div`. Accepts one RV64M divide/remainder op at a time over a valid/ready handshake, issues it to the divider as a single-cycle pulse, and captures the divider's one-cycle result. Applies RISC-V divide-by-zero and signed-overflow semantics and sign-extends W results. Handles pipeline flush without corrupting the divider.

## Interface
- No parameters; XLEN fixed at 64.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  EXU op valid
- req_ready  out  1  controller can accept
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_word  in  1  W variant (32-bit operands)
- req_src1  in  64  dividend
- req_src2  in  64  divisor
- flush  in  1  kill in-flight op
- resp_valid  out  1  result valid
- resp_ready  in  1  EXU takes result
- resp_data  out  64  final result
- busy  out  1  state != IDLE
- div_valid, div_divw, div_signed, div_mode  out  1 each  to divider
- div_dividend, div_divisor  out  64  to divider (registered operands)
- div_out_valid  in  1  divider result strobe (one cycle)
- div_result  in  64  divider result

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. Reset -> IDLE.
- req_ready = (state==IDLE) & ~flush. Fire = req_valid & req_ready; latch op, word, src1, src2.
- Fire: IDLE->ISSUE (or IDLE->RESP for special cases when fast path is compiled in).
- ISSUE: div_valid=1 for exactly one cycle; div_signed = ~op[0]; div_mode = op[1]; div_divw = word. -> WAIT.
- WAIT: on div_out_valid capture result -> RESP.
- RESP: resp_valid=1; hold resp_data stable until resp_ready -> IDLE.
- Special cases, evaluated on low 32 bits when word=1:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, signed op only): quotient = dividend; remainder = 0.
- Normal W result: resp_data = sign-extension of div_result[31:0]. Applies to all four W ops, per RV64.
- Normal 64-bit result: resp_data = div_result.
- Flush handling:
  - IDLE: no accept.
  - ISSUE or WAIT: -> DRAIN. div_valid still pulses if in ISSUE.
  - DRAIN: wait for div_out_valid, discard it -> IDLE.
  - RESP: drop result, -> IDLE.
- div_out_valid outside WAIT/DRAIN is ignored.
- Flush and resp_ready in the same RESP cycle: the result counts as not delivered.

## Timing
- Outputs at reset: req_ready=0 while rst low, then 1; resp_valid=0; resp_data=0; div_valid=0; busy=0; div_* operand outputs=0.
- Normal op: fire at edge 0, ISSUE cycle 1, divider strobe cycle 3, resp_valid cycle 4.
- The controller never relies on fixed divider latency; it waits on div_out_valid.
- Fast-path op: resp_valid in the cycle after fire.
- Back-to-back: resp handshake at edge N gives IDLE; next fire no earlier than edge N+1. This guarantees the divider's busy flag has cleared before the next div_valid.
- rst must be held low ≥4 cycles so that any divider op in flight completes.

## Configuration
- `DIV_CTRL_FASTPATH_EN` defined: special-case ops skip the divider, going IDLE->RESP with a one-cycle latency.
- Undefined: special-case ops traverse ISSUE/WAIT like normal ops. At capture, div_result is discarded and the fixup value is substituted. Results are identical; only latency differs.

## Structure
- Package `ysyx_22041412_div_pkg`: state enum, req_op encodings, XLEN constant.
- Sub-module `ysyx_22041412_div_fixup`: combinational. Detects div-by-zero and overflow, forms the substitute result, and sign-extends W results. Used by the controller at capture or fire.

## Test plan
- DIV src1=-7, src2=2 -> resp_data=-3, resp_valid 4 cycles after fire. REM of the same operands -> -1.
- DIVUW src1=0xFFFF_FFFF_8000_0000, src2=1 -> 0xFFFF_FFFF_8000_0000 (sign-extended W result).
- DIVU src2=0 -> all ones. REMW src1=0x1_8000_0001, src2=0 -> 0xFFFF_FFFF_8000_0001. Latency is 1 or 4 cycles per macro setting.
- DIV src1=0x8000_0000_0000_0000, src2=-1 -> src1. REM of the same operands -> 0. DIVW src1=0x8000_0000, src2=-1 -> 0xFFFF_FFFF_8000_0000.
- Flush in WAIT -> busy=1 until div_out_valid, then IDLE, no resp_valid. The next DIVU 100/7 returns 14.
- Hold resp_ready=0 for 5 cycles -> resp_data stable and req_ready=0 throughout. The handshake then returns to IDLE.
